// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV32I load/store controller between execute and a byte-enabled
// data memory (synchronous write, combinational read).
// Optional feature macro: LSU_MISALIGN_EN -- when defined, accesses crossing a
// 4-byte boundary are split into two word accesses; otherwise they are rejected.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_ready,
  output logic                  o_done,
  output logic                  o_err,
  output logic [DATA_WIDTH-1:0] o_ld_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_wren,
  output logic [3:0]            o_mem_wbe,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
`ifdef LSU_MISALIGN_EN
    SECOND,
`endif
    RESP
  } state_t;

  state_t          state;
  logic [1:0]      off;
  logic [2:0]      f3;
  logic            ld_ok;
  logic            err;
  logic            mem_wren;
  logic [3:0]      mem_wbe;

`ifdef LSU_MISALIGN_EN
  logic            split;
  logic [31:0]     hi_addr;
  logic [3:0]      hi_wbe;
  logic [31:0]     hi_wdata;
  logic [31:0]     rd_lo;
`endif

  // Byte-lane mask of an access: size from funct3[1:0], shifted to its offset.
  function automatic logic [7:0] lane_mask(input logic [1:0] size_code, input logic [1:0] lane);
    logic [7:0] base;
    case (size_code)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << lane;
  endfunction

  function automatic logic req_valid(input logic store, input logic [2:0] code);
    case (code)
      3'b000, 3'b001, 3'b010: return 1'b1;
      3'b100, 3'b101:         return !store;
      default:                return 1'b0;
    endcase
  endfunction

  // Right-align the addressed bytes of the two-word window and extend.
  function automatic logic [31:0] extend(input logic [63:0] raw, input logic [1:0] sel_off,
                                         input logic [2:0] code);
    logic [31:0] sh;
    sh = 32'(raw >> {sel_off, 3'b000});
    case (code)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  logic [1:0]  in_off;
  logic [7:0]  in_mask;
  logic        in_cross;
  logic        in_skip;
  logic [31:0] in_base;
  logic [31:0] wd_lo;

  assign in_off   = i_addr[1:0];
  assign in_mask  = lane_mask(i_funct3[1:0], in_off);
  assign in_cross = |in_mask[7:4];
  assign in_base  = {i_addr[31:2], 2'b00};
  assign wd_lo    = i_wdata << {in_off, 3'b000};

`ifdef LSU_MISALIGN_EN
  logic [31:0] wd_hi;
  assign wd_hi   = 32'(({32'b0, i_wdata} << {in_off, 3'b000}) >> 32);
  assign in_skip = !req_valid(i_we, i_funct3);
`else
  assign in_skip = !req_valid(i_we, i_funct3) || in_cross;
`endif

  assign o_ready = (state == IDLE);

  // Reset suppresses an access in flight so an interrupted split store never
  // commits its second half on the edge that takes the FSM back to IDLE.
  assign o_mem_wren = mem_wren && !i_reset;
  assign o_mem_wbe  = i_reset ? '0 : mem_wbe;

  // Request sequencing: accept, drive up to two word accesses, then respond.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state       <= IDLE;
      off         <= '0;
      f3          <= '0;
      ld_ok       <= 1'b0;
      err         <= 1'b0;
      mem_wren    <= 1'b0;
      mem_wbe     <= '0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_ld_data   <= '0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
`ifdef LSU_MISALIGN_EN
      split       <= 1'b0;
      hi_addr     <= '0;
      hi_wbe      <= '0;
      hi_wdata    <= '0;
      rd_lo       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_req) begin
            state <= FIRST;
            off   <= in_off;
            f3    <= i_funct3;
            ld_ok <= !i_we && !in_skip;
            err   <= in_skip;
            if (!in_skip) begin
              o_mem_addr  <= in_base;
              mem_wren    <= i_we;
              mem_wbe     <= i_we ? in_mask[3:0] : '0;
              o_mem_wdata <= i_we ? wd_lo : '0;
            end
`ifdef LSU_MISALIGN_EN
            split    <= in_cross && !in_skip;
            hi_addr  <= in_base + 32'd4;
            hi_wbe   <= i_we ? in_mask[7:4] : '0;
            hi_wdata <= i_we ? wd_hi : '0;
`endif
          end
        end
        FIRST: begin
`ifdef LSU_MISALIGN_EN
          if (split) begin
            state       <= SECOND;
            rd_lo       <= i_mem_rdata;
            o_mem_addr  <= hi_addr;
            mem_wbe     <= hi_wbe;
            mem_wren    <= (hi_wbe != '0);
            o_mem_wdata <= hi_wdata;
          end else
`endif
          begin
            state       <= RESP;
            o_done      <= 1'b1;
            o_err       <= err;
            o_mem_addr  <= '0;
            mem_wren    <= 1'b0;
            mem_wbe     <= '0;
            o_mem_wdata <= '0;
            if (ld_ok) o_ld_data <= extend({32'b0, i_mem_rdata}, off, f3);
          end
        end
`ifdef LSU_MISALIGN_EN
        SECOND: begin
          state       <= RESP;
          o_done      <= 1'b1;
          o_err       <= err;
          o_mem_addr  <= '0;
          mem_wren    <= 1'b0;
          mem_wbe     <= '0;
          o_mem_wdata <= '0;
          if (ld_ok) o_ld_data <= extend({i_mem_rdata, rd_lo}, off, f3);
        end
`endif
        RESP: begin
          state  <= IDLE;
          o_done <= 1'b0;
          o_err  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes expected memory writes and
// responses; a negedge monitor pops and compares against DUT activity.
module tb_lsu_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_ready;
  logic        o_done;
  logic        o_err;
  logic [31:0] o_ld_data;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic        o_mem_wren;
  logic [3:0]  o_mem_wbe;
  logic [31:0] i_mem_rdata;

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_req(i_req), .i_we(i_we),
    .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_ready(o_ready), .o_done(o_done), .o_err(o_err), .o_ld_data(o_ld_data),
    .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wren(o_mem_wren),
    .o_mem_wbe(o_mem_wbe), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // 16-word memory; 0x2000.. maps to 8.., 0x0 to 0, 0xFFFFFFFC to 15.
  logic [31:0] mem [16] = '{default: '0};
  function automatic logic [3:0] midx(input logic [31:0] a);
    return {a[13], a[4:2]};
  endfunction
  assign i_mem_rdata = mem[midx(o_mem_addr)];
  always @(posedge i_clk) begin
    if (o_mem_wren)
      for (int k = 0; k < 4; k++)
        if (o_mem_wbe[k]) mem[midx(o_mem_addr)][8*k +: 8] <= o_mem_wdata[8*k +: 8];
  end

  typedef struct { logic [31:0] addr; logic [3:0] wbe; logic [31:0] wdata; } wr_t;
  typedef struct { logic err; logic [31:0] ld; int dcyc; } resp_t;
  wr_t   wq[$];
  resp_t rq[$];
  wr_t   wcur;
  resp_t rcur;

  int vecs = 0;
  int miss = 0;
  logic [31:0] exp_ld = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  // Monitor: every memory write and every completion is matched to the queues.
  always @(negedge i_clk) begin
    if (o_mem_wren) begin
      if (wq.size() == 0) begin
        vecs++; miss++;
        $display("FAIL unexpected_write: got addr %h wbe %b, expected no write", o_mem_addr, o_mem_wbe);
      end else begin
        wcur = wq.pop_front();
        chk("wr_addr", o_mem_addr, wcur.addr);
        chk("wr_wbe", {28'b0, o_mem_wbe}, {28'b0, wcur.wbe});
        chk("wr_data", o_mem_wdata, wcur.wdata);
      end
    end
    if (o_done) begin
      if (rq.size() == 0) begin
        vecs++; miss++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        rcur = rq.pop_front();
        chk("resp_err", {31'b0, o_err}, {31'b0, rcur.err});
        chk("resp_ld", o_ld_data, rcur.ld);
        chk("done_cycle", 32'(cyc), 32'(rcur.dcyc));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!o_ready && n < 50) begin
      @(posedge i_clk); #1;
      n++;
    end
    if (!o_ready) begin
      vecs++; miss++;
      $display("FAIL ready_timeout: got o_ready 0, expected 1 within 50 cycles");
    end
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    wq.push_back('{addr: a, wbe: be, wdata: d});
  endtask

  // Issue one request; lat is the cycle (counted from accept) carrying o_done.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input int lat, input logic err,
                       input logic upd, input logic [31:0] ld);
    wait_ready();
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    if (upd) exp_ld = ld;
    rq.push_back('{err: err, ld: exp_ld, dcyc: cyc + lat - 1});
  endtask

  // Called in FIRST of a rejected request: no access may appear.
  task automatic quiet(input string name);
    chk({name, "_addr"}, o_mem_addr, 32'h0);
    chk({name, "_wren"}, {31'b0, o_mem_wren}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset = 1'b1; i_req = 1'b0; i_we = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst_ready", {31'b0, o_ready}, 32'h1);
    chk("rst_done", {31'b0, o_done}, 32'h0);
    chk("rst_err", {31'b0, o_err}, 32'h0);
    chk("rst_ld", o_ld_data, 32'h0);
    chk("rst_wren", {31'b0, o_mem_wren}, 32'h0);
    chk("rst_wbe", {28'b0, o_mem_wbe}, 32'h0);
    chk("rst_addr", o_mem_addr, 32'h0);
    chk("rst_wdata", o_mem_wdata, 32'h0);
    i_reset = 1'b0;
    @(posedge i_clk); #1;

    exp_wr(32'h2000, 4'b1111, 32'hDEADBEEF);
    issue(1, 3'b010, 32'h2000, 32'hDEADBEEF, 2, 0, 0, 0);
    issue(0, 3'b010, 32'h2000, 0, 2, 0, 1, 32'hDEADBEEF);
    exp_wr(32'h2004, 4'b1111, 32'h80FF7F01);
    issue(1, 3'b010, 32'h2004, 32'h80FF7F01, 2, 0, 0, 0);
    issue(0, 3'b000, 32'h2006, 0, 2, 0, 1, 32'hFFFFFFFF);
    issue(0, 3'b100, 32'h2007, 0, 2, 0, 1, 32'h00000080);
    issue(0, 3'b001, 32'h2006, 0, 2, 0, 1, 32'hFFFF80FF);
    issue(0, 3'b101, 32'h2005, 0, 2, 0, 1, 32'h0000FF7F);
    exp_wr(32'h2000, 4'b1000, 32'hAB000000);
    issue(1, 3'b000, 32'h2003, 32'h000000AB, 2, 0, 0, 0);
    issue(0, 3'b010, 32'h2000, 0, 2, 0, 1, 32'hABADBEEF);

    issue(0, 3'b011, 32'h2000, 0, 2, 1, 0, 0);
    quiet("bad_load");
    issue(1, 3'b100, 32'h2000, 32'h12345678, 2, 1, 0, 0);
    quiet("bad_store");

`ifdef LSU_MISALIGN_EN
    exp_wr(32'h2000, 4'b1100, 32'h33440000);
    exp_wr(32'h2004, 4'b0011, 32'h00001122);
    issue(1, 3'b010, 32'h2002, 32'h11223344, 3, 0, 0, 0);
    issue(0, 3'b010, 32'h2002, 0, 3, 0, 1, 32'h11223344);
    exp_wr(32'hFFFFFFFC, 4'b1111, 32'hAABBCCDD);
    issue(1, 3'b010, 32'hFFFFFFFC, 32'hAABBCCDD, 2, 0, 0, 0);
    exp_wr(32'h00000000, 4'b1111, 32'h55667788);
    issue(1, 3'b010, 32'h00000000, 32'h55667788, 2, 0, 0, 0);
    issue(0, 3'b010, 32'hFFFFFFFE, 0, 3, 0, 1, 32'h7788AABB);
    chk("wrap_first_addr", o_mem_addr, 32'hFFFFFFFC);
`else
    issue(0, 3'b010, 32'h2003, 0, 2, 1, 0, 0);
    quiet("cross_lw");
    @(posedge i_clk); #1;
    chk("cross_lw_resp_addr", o_mem_addr, 32'h0);
    issue(1, 3'b010, 32'h2002, 32'h11223344, 2, 1, 0, 0);
    quiet("cross_sw");
    issue(0, 3'b001, 32'h2007, 0, 2, 1, 0, 0);
    quiet("cross_lh");
`endif

    // Reset mid-operation: no completion, back to IDLE on the next edge.
    wait_ready();
    i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_wdata = 32'hCAFEF00D;
`ifdef LSU_MISALIGN_EN
    i_addr = 32'h200A;
    exp_wr(32'h2008, 4'b1100, 32'hF00D0000);
    @(posedge i_clk); #1;
    i_req = 1'b0;
    @(posedge i_clk); #1;
`else
    i_addr = 32'h2008;
    @(posedge i_clk); #1;
    i_req = 1'b0;
`endif
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    exp_ld = '0;
    chk("rst_mid_ready", {31'b0, o_ready}, 32'h1);
    chk("rst_mid_done", {31'b0, o_done}, 32'h0);
    chk("rst_mid_ld", o_ld_data, 32'h0);
`ifdef LSU_MISALIGN_EN
    issue(0, 3'b010, 32'h2008, 0, 2, 0, 1, 32'hF00D0000);
    issue(0, 3'b010, 32'h200C, 0, 2, 0, 1, 32'h00000000);
`else
    issue(0, 3'b010, 32'h2008, 0, 2, 0, 1, 32'h00000000);
    issue(0, 3'b010, 32'h2000, 0, 2, 0, 1, 32'hABADBEEF);
`endif

    // Request held high through the whole operation must be taken once.
    wait_ready();
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h2004; i_wdata = '0;
    @(posedge i_clk); #1;
`ifdef LSU_MISALIGN_EN
    exp_ld = 32'h80FF1122;
`else
    exp_ld = 32'h80FF7F01;
`endif
    rq.push_back('{err: 1'b0, ld: exp_ld, dcyc: cyc + 1});
    chk("held_busy", {31'b0, o_ready}, 32'h0);
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_req = 1'b0;
    chk("held_idle", {31'b0, o_ready}, 32'h1);
    @(posedge i_clk); #1;
    chk("held_once", {31'b0, o_ready}, 32'h1);

    repeat (4) @(posedge i_clk);
    #1;
    chk("pending_writes", 32'(wq.size()), 32'h0);
    chk("pending_resps", 32'(rq.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
